// File: rtl/jtag_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtag_seq_pkg : opcodes, header field positions and FSM states shared by     |
// |                the JTAG shift sequencer.                                    |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
package jtag_seq_pkg;

    localparam logic [1:0] OP_SET_DIV = 2'b00;
    localparam logic [1:0] OP_PINS    = 2'b01;
    localparam logic [1:0] OP_SHIFT   = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    localparam int HDR_OP_MSB   = 7;
    localparam int HDR_OP_LSB   = 6;
    localparam int HDR_CAP_BIT  = 5;
    localparam int HDR_DIV_MSB  = 5;
    localparam int HDR_LEN_MSB  = 2;
    localparam int HDR_TRST_BIT = 1;
    localparam int HDR_SRST_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_TMS = 3'd1,
        ST_GET_TDI = 3'd2,
        ST_TCK_LO  = 3'd3,
        ST_TCK_HI  = 3'd4,
        ST_EMIT    = 3'd5
    } seq_state_e;

    function automatic logic is_cmd_state(input seq_state_e s);
        return (s == ST_IDLE) || (s == ST_GET_TMS) || (s == ST_GET_TDI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tck_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtag_tck_gen : half-period down counter; flags the last clk cycle of each  |
// |                TCK low and high phase.                                      |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
module jtag_tck_gen #(
    parameter int DIV_W = 6
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             active_i,
    input  logic             hi_phase_i,
    output logic             lo_done_o,
    output logic             hi_done_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             w_expired;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = div_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Each phase is loaded on entry, so a zero count marks its final cycle.
    assign w_expired = active_i && (cnt_q == '0);
    assign lo_done_o = w_expired && !hi_phase_i;
    assign hi_done_o = w_expired && hi_phase_i;

endmodule
`default_nettype wire

// File: rtl/jtag_shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtag_shift_sequencer : byte-command JTAG sequencer; decodes header/payload |
// |                        bytes, clocks 1..8 TAP bits, returns TDO bytes.     |
// | Revision             : 1.0                                                  |
// +----------------------------------------------------------------------------+
module jtag_shift_sequencer
    import jtag_seq_pkg::*;
#(
    parameter logic [5:0] DIV_RESET   = 6'd3,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic       tck,
    output logic       tms,
    output logic       tdi,
    output logic       trst,
    output logic       srst,
    input  logic       tdo,
    output logic       busy_o
);

    seq_state_e             state_q, state_d;
    logic                   cmd_ready_q;
    logic [5:0]             div_q;
    logic                   trst_q, srst_q;
    logic                   cap_en_q;
    logic [2:0]             last_bit_q;
    logic [2:0]             bit_q;
    logic [7:0]             tms_sh_q, tdi_sh_q;
    logic                   tck_q, tms_q, tdi_q;
    logic [7:0]             cap_q;
    logic [7:0]             rsp_data_q;
    logic                   rsp_valid_q;
    logic [SYNC_STAGES-1:0] sync_q;

    logic       w_accept, w_load, w_lo_done, w_hi_done, w_last, w_tdo_s;
    logic [1:0] w_op;
    logic [7:0] w_cap_next;

    assign w_accept = cmd_valid_i && cmd_ready_q;
    assign w_op     = cmd_data_i[HDR_OP_MSB:HDR_OP_LSB];
    assign w_last   = (bit_q == last_bit_q);
    assign w_tdo_s  = sync_q[SYNC_STAGES-1];

    jtag_tck_gen #(.DIV_W(6)) u_tck_gen (
        .clk        (clk),
        .rst_i      (rst_i),
        .load_i     (w_load),
        .div_i      (div_q),
        .active_i   ((state_q == ST_TCK_LO) || (state_q == ST_TCK_HI)),
        .hi_phase_i (state_q == ST_TCK_HI),
        .lo_done_o  (w_lo_done),
        .hi_done_o  (w_hi_done)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_load  = 1'b0;
        case (state_q)
            ST_IDLE:    if (w_accept && (w_op == OP_SHIFT)) state_d = ST_GET_TMS;
            ST_GET_TMS: if (w_accept) state_d = ST_GET_TDI;
            ST_GET_TDI: if (w_accept) begin
                state_d = ST_TCK_LO;
                w_load  = 1'b1;
            end
            ST_TCK_LO:  if (w_lo_done) begin
                state_d = ST_TCK_HI;
                w_load  = 1'b1;
            end
            ST_TCK_HI:  if (w_hi_done) begin
                if (!w_last) begin
                    state_d = ST_TCK_LO;
                    w_load  = 1'b1;
                end else if (cap_en_q) begin
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT:    if (rsp_ready_i) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cap_next        = cap_q;
        w_cap_next[bit_q] = w_tdo_s;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cmd_ready_q <= 1'b0;
            div_q       <= DIV_RESET;
            trst_q      <= 1'b0;
            srst_q      <= 1'b0;
            cap_en_q    <= 1'b0;
            last_bit_q  <= 3'd0;
            bit_q       <= 3'd0;
            tms_sh_q    <= 8'd0;
            tdi_sh_q    <= 8'd0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            cap_q       <= 8'd0;
            rsp_data_q  <= 8'd0;
            rsp_valid_q <= 1'b0;
            sync_q      <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], tdo};
            // Dropping ready for a cycle after every accept keeps it from leaking into TCK_LO.
            cmd_ready_q <= is_cmd_state(state_q) && !w_accept;
            tck_q       <= (state_d == ST_TCK_HI);

            if (w_accept && (state_q == ST_IDLE)) begin
                case (w_op)
                    OP_SET_DIV: div_q <= cmd_data_i[HDR_DIV_MSB:0];
                    OP_PINS: begin
                        trst_q <= cmd_data_i[HDR_TRST_BIT];
                        srst_q <= cmd_data_i[HDR_SRST_BIT];
                    end
                    OP_SHIFT: begin
                        cap_en_q   <= cmd_data_i[HDR_CAP_BIT];
                        last_bit_q <= cmd_data_i[HDR_LEN_MSB:0];
                    end
                    default: ;
                endcase
            end

            if (w_accept && (state_q == ST_GET_TMS)) begin
                tms_sh_q <= cmd_data_i;
            end

            if (w_accept && (state_q == ST_GET_TDI)) begin
                tms_q    <= tms_sh_q[0];
                tdi_q    <= cmd_data_i[0];
                tms_sh_q <= tms_sh_q >> 1;
                tdi_sh_q <= cmd_data_i >> 1;
                bit_q    <= 3'd0;
                cap_q    <= 8'd0;
            end

            if ((state_q == ST_TCK_HI) && w_hi_done) begin
                cap_q <= w_cap_next;
                if (!w_last) begin
                    bit_q    <= bit_q + 3'd1;
                    tms_q    <= tms_sh_q[0];
                    tdi_q    <= tdi_sh_q[0];
                    tms_sh_q <= tms_sh_q >> 1;
                    tdi_sh_q <= tdi_sh_q >> 1;
                end else if (cap_en_q) begin
                    rsp_data_q  <= w_cap_next;
                    rsp_valid_q <= 1'b1;
                end
            end

            if ((state_q == ST_EMIT) && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_valid_o = rsp_valid_q;
    assign tck         = tck_q;
    assign tms         = tms_q;
    assign tdi         = tdi_q;
    assign trst        = trst_q;
    assign srst        = srst_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jtag_shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_jtag_shift_sequencer : directed self-checking bench for the JTAG shift  |
// |                           sequencer.                                        |
// | Revision                : 1.0                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_jtag_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] cmd_data_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] rsp_data_o;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic       tck, tms, tdi, trst, srst;
    logic       tdo;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jtag_shift_sequencer #(
        .DIV_RESET   (6'd3),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .tck         (tck),
        .tms         (tms),
        .tdi         (tdi),
        .trst        (trst),
        .srst        (srst),
        .tdo         (tdo),
        .busy_o      (busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one time step after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard       = 0;
        cmd_data_i  = b;
        cmd_valid_i = 1'b1;
        while (!cmd_ready_o && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            failures++;
            $display("FAIL send_byte: byte %h never accepted within 200 cycles", b);
        end
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({tck, tms, tdi, trst, srst, rsp_valid_o, cmd_ready_o, busy_o} !== 8'b0100_0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 01000000 (tck,tms,tdi,trst,srst,rsp_v,rdy,busy)",
                     {tck, tms, tdi, trst, srst, rsp_valid_o, cmd_ready_o, busy_o});
        end
        checks++;
        if (rsp_data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_rsp_data: got %h required 00", rsp_data_o);
        end
        rst_i = 1'b0;
        tick();
        tick();
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b required 1", cmd_ready_o);
        end
    endtask

    task automatic test_shift8_cap();
        logic [7:0] tdi_pat;
        logic       exp_tck;
        tdi_pat     = 8'hA5;
        tdo         = 1'b1;
        rsp_ready_i = 1'b0;
        send_byte(8'h05);
        send_byte(8'hA7);
        send_byte(8'h00);
        send_byte(8'hA5);
        for (int k = 0; k < 96; k++) begin
            exp_tck = ((k % 12) >= 6);
            checks++;
            if ({tck, tms, tdi, busy_o, rsp_valid_o} !== {exp_tck, 1'b0, tdi_pat[k/12], 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL shift8_wave cyc %0d: got %b required %b (tck,tms,tdi,busy,rsp_v)", k,
                         {tck, tms, tdi, busy_o, rsp_valid_o}, {exp_tck, 1'b0, tdi_pat[k/12], 1'b1, 1'b0});
            end
            tick();
        end
        checks++;
        if ({rsp_valid_o, rsp_data_o, tck, tdi} !== {1'b1, 8'hFF, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL shift8_rsp: got v=%b d=%h tck=%b tdi=%b required v=1 d=ff tck=0 tdi=1",
                     rsp_valid_o, rsp_data_o, tck, tdi);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        checks++;
        if ({rsp_valid_o, busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL shift8_release: got rsp_v=%b busy=%b required 0 0", rsp_valid_o, busy_o);
        end
    endtask

    task automatic test_shift3_nocap();
        logic [7:0] tms_pat;
        logic [7:0] tdi_pat;
        logic       exp_tck;
        tms_pat = 8'h05;
        tdi_pat = 8'h02;
        send_byte(8'h03);
        send_byte(8'h82);
        send_byte(8'h05);
        send_byte(8'h02);
        for (int k = 0; k < 24; k++) begin
            exp_tck = ((k % 8) >= 4);
            checks++;
            if ({tck, tms, tdi, busy_o} !== {exp_tck, tms_pat[k/8], tdi_pat[k/8], 1'b1}) begin
                failures++;
                $display("FAIL shift3_wave cyc %0d: got %b required %b (tck,tms,tdi,busy)", k,
                         {tck, tms, tdi, busy_o}, {exp_tck, tms_pat[k/8], tdi_pat[k/8], 1'b1});
            end
            tick();
        end
        checks++;
        if ({busy_o, tck, rsp_valid_o, tms, tdi} !== 5'b00010) begin
            failures++;
            $display("FAIL shift3_end: got %b required 00010 (busy,tck,rsp_v,tms,tdi)",
                     {busy_o, tck, rsp_valid_o, tms, tdi});
        end
        repeat (5) tick();
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL shift3_no_rsp: got rsp_v=%b required 0", rsp_valid_o);
        end
    endtask

    task automatic test_tdo_capture();
        logic [3:0] tdo_pat;
        logic       exp_tck;
        tdo_pat     = 4'b1101;
        rsp_ready_i = 1'b0;
        send_byte(8'hA3);
        send_byte(8'h0F);
        tdo = tdo_pat[0];
        send_byte(8'h00);
        for (int k = 0; k < 32; k++) begin
            tdo     = tdo_pat[k/8];
            exp_tck = ((k % 8) >= 4);
            checks++;
            if ({tck, tms, cmd_ready_o} !== {exp_tck, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL cap_wave cyc %0d: got %b required %b (tck,tms,rdy)", k,
                         {tck, tms, cmd_ready_o}, {exp_tck, 1'b1, 1'b0});
            end
            tick();
        end
        for (int k = 0; k < 21; k++) begin
            checks++;
            if ({rsp_valid_o, rsp_data_o, cmd_ready_o} !== {1'b1, 8'h0D, 1'b0}) begin
                failures++;
                $display("FAIL cap_hold cyc %0d: got v=%b d=%h rdy=%b required v=1 d=0d rdy=0", k,
                         rsp_valid_o, rsp_data_o, cmd_ready_o);
            end
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        tdo         = 1'b1;
        checks++;
        if ({rsp_valid_o, busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL cap_release: got rsp_v=%b busy=%b required 0 0", rsp_valid_o, busy_o);
        end
    endtask

    task automatic test_pins();
        send_byte(8'h43);
        checks++;
        if ({trst, srst} !== 2'b11) begin
            failures++;
            $display("FAIL pins_43: got trst,srst=%b required 11", {trst, srst});
        end
        send_byte(8'h41);
        checks++;
        if ({trst, srst} !== 2'b01) begin
            failures++;
            $display("FAIL pins_41: got trst,srst=%b required 01", {trst, srst});
        end
        send_byte(8'hC0);
        checks++;
        if ({trst, srst, rsp_valid_o, busy_o} !== 4'b0100) begin
            failures++;
            $display("FAIL rsvd_c0: got %b required 0100 (trst,srst,rsp_v,busy)",
                     {trst, srst, rsp_valid_o, busy_o});
        end
        tick();
        tick();
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rsvd_ready: got rdy=%b required 1", cmd_ready_o);
        end
    endtask

    task automatic test_stall();
        logic exp_tck;
        send_byte(8'h82);
        send_byte(8'h05);
        for (int j = 0; j < 10; j++) begin
            checks++;
            if ({tck, busy_o} !== 2'b01 || (j >= 1 && cmd_ready_o !== 1'b1)) begin
                failures++;
                $display("FAIL stall cyc %0d: got tck=%b busy=%b rdy=%b required tck=0 busy=1 rdy=1", j,
                         tck, busy_o, cmd_ready_o);
            end
            tick();
        end
        send_byte(8'h02);
        for (int k = 0; k < 24; k++) begin
            exp_tck = ((k % 8) >= 4);
            checks++;
            if (tck !== exp_tck) begin
                failures++;
                $display("FAIL stall_resume cyc %0d: got tck=%b required %b", k, tck, exp_tck);
            end
            tick();
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_done: got busy=%b required 0", busy_o);
        end
    endtask

    task automatic test_reset_mid_shift();
        int saw_activity;
        rsp_ready_i = 1'b0;
        send_byte(8'hA7);
        send_byte(8'h00);
        send_byte(8'hA5);
        repeat (10) tick();
        rst_i = 1'b1;
        #1;
        checks++;
        if ({tck, tms, tdi, trst, srst, rsp_valid_o, cmd_ready_o, busy_o, rsp_data_o} !==
            {8'b0100_0000, 8'h00}) begin
            failures++;
            $display("FAIL midshift_reset: got %b_%h required 01000000_00 (tck,tms,tdi,trst,srst,rsp_v,rdy,busy_data)",
                     {tck, tms, tdi, trst, srst, rsp_valid_o, cmd_ready_o, busy_o}, rsp_data_o);
        end
        @(posedge clk);
        #1;
        rst_i        = 1'b0;
        saw_activity = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || tck !== 1'b0) saw_activity++;
        end
        checks++;
        if (saw_activity != 0) begin
            failures++;
            $display("FAIL midshift_aborted: got %0d active cycles required 0", saw_activity);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        cmd_data_i  = 8'h00;
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        tdo         = 1'b1;
        test_reset();
        test_shift8_cap();
        test_shift3_nocap();
        test_tdo_capture();
        test_pins();
        test_stall();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
